// File: rtl/ifu_pc_ctrl.sv
// IF-stage PC sequencer: next-PC selection, AdEL fetch-fault detection and fault hold.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count, a count of issued non-stalled fetches.
module ifu_pc_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int unsigned IM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [11:0] im_addr,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic [4:0]  exc_code
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1
  } state_t;

  // Upper bound kept in 33 bits so a ROM ending at 2^32 does not wrap the compare.
  localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

  state_t state;
  logic   illegal;

  assign illegal = (pc[1:0] != 2'b00) || (pc < PC_RESET) || ({1'b0, pc} >= PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RESET;
      state <= ST_RUN;
    end else if (exc_req) begin
      pc    <= EXC_ENTRY;
      state <= ST_RUN;
    end else if (eret_req) begin
      pc    <= epc;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          // A stalled illegal PC stays in RUN so the stall can resolve first.
          if (!stall) begin
            if (illegal)             state <= ST_FAULT;
            else if (redirect_valid) pc    <= redirect_pc;
            else                     pc    <= pc + 32'd4;
          end
        end
        ST_FAULT: ;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign fetch_fault = illegal || (state == ST_FAULT);
  assign fetch_valid = (state == ST_RUN) && !illegal;
  assign exc_code    = fetch_fault ? 5'd4 : 5'd0;
  assign im_addr     = 12'((pc - PC_RESET) >> 2);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      fetch_count <= 32'd0;
    else if (fetch_valid && !stall)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Bench for ifu_pc_ctrl: directed vector table, perf-counter sequence, randomized run vs reference model.
module tb_ifu_pc_ctrl;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam int unsigned IM_WORDS  = 4096;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_pc, epc;
  logic [31:0] pc;
  logic [11:0] im_addr;
  logic        fetch_valid, fetch_fault;
  logic [4:0]  exc_code;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifu_pc_ctrl #(.PC_RESET(PC_RESET), .EXC_ENTRY(EXC_ENTRY), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc), .im_addr(im_addr), .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault), .exc_code(exc_code)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  typedef struct {
    bit          rst, stl, rv;
    logic [31:0] rpc;
    bit          exc, eret;
    logic [31:0] epcv;
    logic [31:0] e_pc;
    logic [11:0] e_im;
    bit          e_fv, e_ff;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit stl, bit rv, logic [31:0] rpc, bit exc, bit eret,
                              logic [31:0] epcv, logic [31:0] e_pc, logic [11:0] e_im,
                              bit e_fv, bit e_ff);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.exc = exc; v.eret = eret;
    v.epcv = epcv; v.e_pc = e_pc; v.e_im = e_im; v.e_fv = e_fv; v.e_ff = e_ff;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(bit rst, bit stl, bit rv, logic [31:0] rpc, bit exc, bit eret,
                       logic [31:0] epcv);
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    exc_req = exc; eret_req = eret; epc = epcv;
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural PC plus a "fault latched" flag.
  logic [31:0] m_pc;
  bit          m_flt;
  logic [31:0] m_cnt;

  function automatic bit is_illegal(logic [31:0] p);
    return (p[1:0] != 2'b00) || (p < PC_RESET) ||
           (longint'(p) >= longint'(PC_RESET) + 4 * longint'(IM_WORDS));
  endfunction

  function automatic void model_step(bit rst, bit stl, bit rv, logic [31:0] rpc, bit exc,
                                     bit eret, logic [31:0] epcv);
    bit bad;
    bad = is_illegal(m_pc);
    if (rst) begin
      m_pc = PC_RESET; m_flt = 0; m_cnt = 0;
      return;
    end
    if (!m_flt && !bad && !stl) m_cnt = m_cnt + 1;
    if (exc)       begin m_pc = EXC_ENTRY; m_flt = 0; end
    else if (eret) begin m_pc = epcv;      m_flt = 0; end
    else if (m_flt || stl) ;
    else if (bad)  m_flt = 1;
    else if (rv)   m_pc = rpc;
    else           m_pc = m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return PC_RESET + ($urandom % IM_WORDS) * 4 + $urandom_range(1, 3);
      2: return 32'h0000_2FFC;
      3: return 32'h0000_6FFC;
      4: return 32'h0000_7000;
      default: return PC_RESET + ($urandom % IM_WORDS) * 4;
    endcase
  endfunction

  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    exc_req = 0; eret_req = 0; epc = 0;

    //   rst stl rv  rpc          exc eret epc         pc           im      fv ff
    add(1, 0, 0, 32'h0,       0, 0, 32'h0,      32'h3000, 12'h000, 1, 0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h3004, 12'h001, 1, 0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h3008, 12'h002, 1, 0);
    add(0, 1, 1, 32'h3100,    0, 0, 32'h0,      32'h3008, 12'h002, 1, 0);
    add(0, 1, 1, 32'h3100,    0, 0, 32'h0,      32'h3008, 12'h002, 1, 0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h300C, 12'h003, 1, 0);
    add(0, 0, 1, 32'h3002,    0, 0, 32'h0,      32'h3002, 12'h000, 0, 1);
    add(0, 0, 1, 32'h3100,    0, 0, 32'h0,      32'h3002, 12'h000, 0, 1);
    add(0, 0, 1, 32'h3100,    0, 0, 32'h0,      32'h3002, 12'h000, 0, 1);
    add(0, 1, 0, 32'h0,       0, 0, 32'h0,      32'h3002, 12'h000, 0, 1);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,      32'h4180, 12'h460, 1, 0);
    add(0, 0, 1, 32'h2FFC,    0, 0, 32'h0,      32'h2FFC, 12'hFFF, 0, 1);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h2FFC, 12'hFFF, 0, 1);
    add(0, 0, 0, 32'h0,       0, 1, 32'h6FFC,   32'h6FFC, 12'hFFF, 1, 0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h7000, 12'h000, 0, 1);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h7000, 12'h000, 0, 1);
    add(0, 1, 1, 32'h3100,    1, 1, 32'h3040,   32'h4180, 12'h460, 1, 0);
    add(0, 0, 0, 32'h0,       0, 1, 32'h3040,   32'h3040, 12'h010, 1, 0);
    add(0, 1, 0, 32'h0,       0, 0, 32'h0,      32'h3040, 12'h010, 1, 0);
    add(0, 0, 1, 32'h3100,    1, 0, 32'h0,      32'h4180, 12'h460, 1, 0);
    add(0, 0, 0, 32'h0,       1, 1, 32'h3040,   32'h4180, 12'h460, 1, 0);
    add(0, 0, 1, 32'h3001,    0, 0, 32'h0,      32'h3001, 12'h000, 0, 1);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,      32'h3001, 12'h000, 0, 1);
    add(1, 0, 1, 32'h3100,    0, 0, 32'h0,      32'h3000, 12'h000, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rpc, vecs[i].exc, vecs[i].eret,
            vecs[i].epcv);
      chk($sformatf("v%0d pc", i),          pc,          vecs[i].e_pc);
      chk($sformatf("v%0d im_addr", i),     32'(im_addr), 32'(vecs[i].e_im));
      chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].e_fv));
      chk($sformatf("v%0d fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].e_ff));
      chk($sformatf("v%0d exc_code", i),    32'(exc_code), vecs[i].e_ff ? 32'd4 : 32'd0);
    end

`ifdef FETCH_PERF_CNT_EN
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("perf reset", fetch_count, 32'd0);
    for (int i = 0; i < 10; i++)
      cycle(0, (i == 3 || i == 7), 0, 0, 0, 0, 0);
    chk("perf 10 cycles 2 stalled", fetch_count, 32'd8);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("perf mid-run reset", fetch_count, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit rst, stl, rv, exc, eret;
      logic [31:0] rpc, epcv;
      rst  = (i == 0) || ($urandom_range(0, 99) < 2);
      stl  = $urandom_range(0, 99) < 20;
      rv   = $urandom_range(0, 99) < 25;
      exc  = $urandom_range(0, 99) < 4;
      eret = $urandom_range(0, 99) < 5;
      rpc  = rnd_addr();
      epcv = rnd_addr();
      model_step(rst, stl, rv, rpc, exc, eret, epcv);
      cycle(rst, stl, rv, rpc, exc, eret, epcv);
      chk("rnd pc",          pc,               m_pc);
      chk("rnd im_addr",     32'(im_addr),     ((m_pc - PC_RESET) / 4) % 4096);
      chk("rnd fetch_valid", 32'(fetch_valid), 32'(!m_flt && !is_illegal(m_pc)));
      chk("rnd fetch_fault", 32'(fetch_fault), 32'(m_flt || is_illegal(m_pc)));
      chk("rnd exc_code",    32'(exc_code),    (m_flt || is_illegal(m_pc)) ? 32'd4 : 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rnd fetch_count", fetch_count, m_cnt);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
